// File: rtl/bin_gray_codec.sv
// -----------------------------------------------------------------------------
// bin_gray_codec
//
// Purpose:
//   Registered binary-to-Gray encoder chained into a registered Gray-to-binary
//   decoder. The encoder produces the Gray code of each accepted word one cycle
//   after it is sampled. The decoder then recovers the original binary word one
//   cycle after that, so the total latency is two cycles.
//   Throughput is one word per cycle and there is no backpressure.
//
// Parameters:
//   MSB        data width in bits. The name is historical: it is a width, not
//              a bit index. The legal range is 1..64.
//
// Ports:
//   clk        input        single clock; all state updates on the rising edge
//   rst        input        synchronous reset, active high; clears all state
//   bin_in     input [MSB]  binary word to encode
//   in_valid   input        bin_in is valid this cycle
//   gray       output [MSB] registered Gray code of the last accepted bin_in
//   gray_valid output       gray was loaded on the last edge
//   bin_out    output [MSB] registered binary value decoded from gray
//   out_valid  output       bin_out was loaded on the last edge
//   rt_err     output       (only with BIN_GRAY_ROUNDTRIP_CHECK_EN) sticky flag:
//                           a valid bin_out differed from the bin_in that was
//                           accepted two cycles earlier
//
// Optional feature macro: BIN_GRAY_ROUNDTRIP_CHECK_EN
//   When this macro is defined, the design adds the rt_err output and a 2-deep
//   delay line of bin_in and in_valid that feeds the round-trip compare. When it
//   is undefined, both are absent and the rest of the behaviour is identical.
// -----------------------------------------------------------------------------
module bin_gray_codec #(
  parameter int unsigned MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MSB-1:0] bin_in,
  input  logic           in_valid,
  output logic [MSB-1:0] gray,
  output logic           gray_valid,
  output logic [MSB-1:0] bin_out,
  output logic           out_valid
`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
  ,
  output logic           rt_err
`endif
);

  // ---------------------------------------------------------------------------
  // Stage 1: encode
  // ---------------------------------------------------------------------------
  logic [MSB-1:0] gray_q, gray_d;
  logic           gray_valid_q, gray_valid_d;

  always_comb begin
    gray_d       = gray_q;
    gray_valid_d = in_valid;
    if (in_valid) begin
      // The top bit passes straight through. Each lower bit is the XOR of a
      // bit and its upper neighbour. For MSB=1 the shift yields zero, so
      // gray equals bin_in.
      gray_d = bin_in ^ (bin_in >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q       <= '0;
      gray_valid_q <= 1'b0;
    end else begin
      gray_q       <= gray_d;
      gray_valid_q <= gray_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: decode
  // ---------------------------------------------------------------------------
  // Decoded bit i is the prefix XOR of gray bits [MSB-1:i], taken from the MSB
  // down. Each bit is written as its own reduction rather than as a chain
  // through the neighbouring decoded bit, so no bit of the vector depends on
  // another bit of the same vector.
  logic [MSB-1:0] bin_dec;

  for (genvar gi = 0; gi < int'(MSB); gi++) begin : g_dec
    assign bin_dec[gi] = ^gray_q[MSB-1:gi];
  end

  logic [MSB-1:0] bin_out_q, bin_out_d;
  logic           out_valid_q, out_valid_d;

  always_comb begin
    bin_out_d   = bin_out_q;
    out_valid_d = gray_valid_q;
    if (gray_valid_q) begin
      bin_out_d = bin_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bin_out_q   <= bin_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gray       = gray_q;
  assign gray_valid = gray_valid_q;
  assign bin_out    = bin_out_q;
  assign out_valid  = out_valid_q;

`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
  // ---------------------------------------------------------------------------
  // Round-trip checker
  // ---------------------------------------------------------------------------
  // The delay line loads on every edge, so it stays aligned with the data
  // pipeline. After a word is accepted, the first stage holds it alongside
  // gray. One edge later, the second stage holds it alongside bin_out.
  logic [MSB-1:0] ref1_q, ref2_q;
  logic           ref1_vld_q, ref2_vld_q;
  logic           rt_err_q, rt_err_d;

  always_comb begin
    rt_err_d = rt_err_q;
    if (out_valid_q && ref2_vld_q && (bin_out_q != ref2_q)) begin
      rt_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref1_q     <= '0;
      ref2_q     <= '0;
      ref1_vld_q <= 1'b0;
      ref2_vld_q <= 1'b0;
      rt_err_q   <= 1'b0;
    end else begin
      ref1_q     <= bin_in;
      ref1_vld_q <= in_valid;
      ref2_q     <= ref1_q;
      ref2_vld_q <= ref1_vld_q;
      rt_err_q   <= rt_err_d;
    end
  end

  assign rt_err = rt_err_q;
`endif

endmodule

// File: tb/tb_bin_gray_codec.sv
// -----------------------------------------------------------------------------
// tb_bin_gray_codec
//
// Directed bench for bin_gray_codec. It uses three instances that share one
// clock and one reset:
//   dut4  MSB=4  main instance (reset, point values, sweep, bubbles, reset)
//   dut8  MSB=8  width check with 8'hA5
//   dut1  MSB=1  degenerate width; fed with bit 0 of the 4-bit stimulus
//
// The bench drives inputs with blocking assignments. It samples outputs 1
// time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bin_gray_codec;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bin4;
  logic       vld;
  logic [7:0] bin8;
  logic [0:0] bin1;

  logic [3:0] gray4, bout4;
  logic       gv4, ov4;
  logic [7:0] gray8, bout8;
  logic       gv8, ov8;
  logic [0:0] gray1, bout1;
  logic       gv1, ov1;

  assign bin1 = bin4[0:0];

`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
  logic rte4, rte8, rte1;
`endif

  always #5 clk = ~clk;

  bin_gray_codec #(.MSB(4)) dut4 (
    .clk(clk), .rst(rst), .bin_in(bin4), .in_valid(vld),
    .gray(gray4), .gray_valid(gv4), .bin_out(bout4), .out_valid(ov4)
`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
    , .rt_err(rte4)
`endif
  );

  bin_gray_codec #(.MSB(8)) dut8 (
    .clk(clk), .rst(rst), .bin_in(bin8), .in_valid(vld),
    .gray(gray8), .gray_valid(gv8), .bin_out(bout8), .out_valid(ov8)
`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
    , .rt_err(rte8)
`endif
  );

  bin_gray_codec #(.MSB(1)) dut1 (
    .clk(clk), .rst(rst), .bin_in(bin1), .in_valid(vld),
    .gray(gray1), .gray_valid(gv1), .bin_out(bout1), .out_valid(ov1)
`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
    , .rt_err(rte1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Hand-written 4-bit reflected Gray table, indexed by the binary value.
  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0] last_in;
    logic [3:0] prev_gray;
    logic [3:0] cur;
    logic [3:0] diff;
    int         ones;

    rst  = 1'b1;
    vld  = 1'b1;
    bin4 = 4'hF;
    bin8 = 8'hA5;

    // Reset is held for two edges while valid data is presented.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_gray",    64'(gray4), 64'h0);
      chk("rst_bin_out", 64'(bout4), 64'h0);
      chk("rst_gv",      64'(gv4),   64'h0);
      chk("rst_ov",      64'(ov4),   64'h0);
      $display("txn reset cycle %0d gray=%h bin_out=%h gv=%b ov=%b", c, gray4, bout4, gv4, ov4);
    end

    // Point values: each gray appears one edge later; bin_out follows one edge after that.
    rst  = 1'b0;
    bin4 = 4'h0;
    tick();
    chk("pt0_gray", 64'(gray4), 64'h0);
    chk("pt0_gv",   64'(gv4),   64'h1);
    chk("pt0_ov",   64'(ov4),   64'h0);
    chk("w8_gray",  64'(gray8), 64'hF7);
    $display("txn point bin_in=0 gray=%h gray8=%h", gray4, gray8);

    bin4 = 4'h5;
    tick();
    chk("pt5_gray",    64'(gray4), 64'h7);
    chk("pt0_bin_out", 64'(bout4), 64'h0);
    chk("pt0_ov1",     64'(ov4),   64'h1);
    chk("w8_bin_out",  64'(bout8), 64'hA5);
    chk("w8_ov",       64'(ov8),   64'h1);
    $display("txn point bin_in=5 gray=%h bin_out=%h bin_out8=%h", gray4, bout4, bout8);

    bin4 = 4'hA;
    tick();
    chk("ptA_gray",    64'(gray4), 64'hF);
    chk("pt5_bin_out", 64'(bout4), 64'h5);
    $display("txn point bin_in=a gray=%h bin_out=%h", gray4, bout4);

    bin4 = 4'hF;
    tick();
    chk("ptF_gray",    64'(gray4), 64'h8);
    chk("ptA_bin_out", 64'(bout4), 64'hA);
    $display("txn point bin_in=f gray=%h bin_out=%h", gray4, bout4);

    // Sweep 0..15 then back to 0, with in_valid held high throughout.
    last_in   = 4'hF;
    prev_gray = 4'h8;
    for (int i = 0; i <= 16; i++) begin
      cur  = 4'(i % 16);
      bin4 = cur;
      tick();
      chk("sw_gray",    64'(gray4), 64'(gray_tbl[cur]));
      chk("sw_bin_out", 64'(bout4), 64'(last_in));
      diff = gray4 ^ prev_gray;
      ones = 0;
      for (int b = 0; b < 4; b++) ones += int'(diff[b]);
      chk("sw_one_bit", 64'(ones), 64'd1);
      chk("w1_gray",    64'(gray1), 64'(cur[0]));
      chk("w1_bin_out", 64'(bout1), 64'(last_in[0]));
`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
      chk("sw_rt_err",  64'(rte4), 64'h0);
      chk("sw_rt_err1", 64'(rte1), 64'h0);
`endif
      $display("txn sweep bin_in=%h gray=%h bin_out=%h", cur, gray4, bout4);
      prev_gray = gray4;
      last_in   = cur;
    end

    // Bubbles: in_valid goes 1,0,1 with bin_in values 3,9,6.
    bin4 = 4'h3; vld = 1'b1;
    tick();
    chk("bb1_gv",      64'(gv4),   64'h1);
    chk("bb1_gray",    64'(gray4), 64'h2);
    chk("bb1_ov",      64'(ov4),   64'h1);
    chk("bb1_bin_out", 64'(bout4), 64'h0);
    $display("txn bubble v=1 bin_in=3 gray=%h gv=%b bin_out=%h ov=%b", gray4, gv4, bout4, ov4);

    bin4 = 4'h9; vld = 1'b0;
    tick();
    chk("bb2_gv",      64'(gv4),   64'h0);
    chk("bb2_gray",    64'(gray4), 64'h2);
    chk("bb2_ov",      64'(ov4),   64'h1);
    chk("bb2_bin_out", 64'(bout4), 64'h3);
    $display("txn bubble v=0 bin_in=9 gray=%h gv=%b bin_out=%h ov=%b", gray4, gv4, bout4, ov4);

    bin4 = 4'h6; vld = 1'b1;
    tick();
    chk("bb3_gv",      64'(gv4),   64'h1);
    chk("bb3_gray",    64'(gray4), 64'h5);
    chk("bb3_ov",      64'(ov4),   64'h0);
    chk("bb3_bin_out", 64'(bout4), 64'h3);
    $display("txn bubble v=1 bin_in=6 gray=%h gv=%b bin_out=%h ov=%b", gray4, gv4, bout4, ov4);

    bin4 = 4'h0; vld = 1'b0;
    tick();
    chk("bb4_gv",      64'(gv4),   64'h0);
    chk("bb4_gray",    64'(gray4), 64'h5);
    chk("bb4_ov",      64'(ov4),   64'h1);
    chk("bb4_bin_out", 64'(bout4), 64'h6);
    $display("txn bubble v=0 gray=%h gv=%b bin_out=%h ov=%b", gray4, gv4, bout4, ov4);

    // Reset asserted mid-stream while data is in flight.
    bin4 = 4'h7; vld = 1'b1;
    tick();
    chk("mr0_gray", 64'(gray4), 64'h4);
    $display("txn midrst pre bin_in=7 gray=%h", gray4);

    bin4 = 4'hC; rst = 1'b1;
    tick();
    chk("mr1_gv",      64'(gv4),   64'h0);
    chk("mr1_ov",      64'(ov4),   64'h0);
    chk("mr1_gray",    64'(gray4), 64'h0);
    chk("mr1_bin_out", 64'(bout4), 64'h0);
    $display("txn midrst rst=1 gv=%b ov=%b", gv4, ov4);

    bin4 = 4'hD; rst = 1'b0;
    tick();
    chk("mr2_gv",   64'(gv4),   64'h1);
    chk("mr2_gray", 64'(gray4), 64'hB);
    chk("mr2_ov",   64'(ov4),   64'h0);
    $display("txn midrst bin_in=d gray=%h gv=%b ov=%b", gray4, gv4, ov4);

    bin4 = 4'hE;
    tick();
    chk("mr3_gray",    64'(gray4), 64'h9);
    chk("mr3_ov",      64'(ov4),   64'h1);
    chk("mr3_bin_out", 64'(bout4), 64'hD);
    $display("txn midrst bin_in=e gray=%h bin_out=%h ov=%b", gray4, bout4, ov4);

    vld = 1'b0;
    tick();
    chk("mr4_gv",      64'(gv4),   64'h0);
    chk("mr4_ov",      64'(ov4),   64'h1);
    chk("mr4_bin_out", 64'(bout4), 64'hE);
`ifdef BIN_GRAY_ROUNDTRIP_CHECK_EN
    chk("end_rt_err",  64'(rte4), 64'h0);
    chk("end_rt_err8", 64'(rte8), 64'h0);
`endif
    $display("txn drain bin_out=%h ov=%b", bout4, ov4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
